// File: rtl/communication_receive.sv
// communication_receive: serial frame receiver with one-entry holding register and valid/ack handshake.
// Optional even-parity checking is enabled by defining COMM_RECV_PARITY_EN.
module communication_receive #(
    parameter int DATA_W = 8
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              rd,
    input  logic              rec_en,
    input  logic              rec_ack,
    output logic [DATA_W-1:0] rec_data,
    output logic              rec_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              finish_send
);
    localparam int CW = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] shift;
`ifdef COMM_RECV_PARITY_EN
    logic              x;
    logic              pbad;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk1) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            shift       <= '0;
            rec_data    <= '0;
            rec_valid   <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
            finish_send <= 1'b0;
`ifdef COMM_RECV_PARITY_EN
            x           <= 1'b0;
            pbad        <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            finish_send <= rec_en && state == IDLE && !rec_valid;
            // a load in STOP below overrides this release
            if (rec_ack && rec_valid)
                rec_valid <= 1'b0;
            if (!rec_en)
                state <= IDLE;
            else
                case (state)
                    IDLE: if (!rd) begin
                        cnt   <= '0;
                        shift <= '0;
                        state <= DATA;
`ifdef COMM_RECV_PARITY_EN
                        x     <= 1'b0;
`endif
                    end
                    DATA: begin
                        shift[cnt] <= rd;
                        cnt        <= cnt + 1'b1;
                        state      <= cnt == CW'(DATA_W - 1) ? PARITY : DATA;
`ifdef COMM_RECV_PARITY_EN
                        x          <= x ^ rd;
`endif
                    end
                    PARITY: begin
                        state <= STOP;
`ifdef COMM_RECV_PARITY_EN
                        pbad  <= rd ^ x;
`endif
                    end
                    default: begin
                        state <= IDLE;
                        if (!rec_valid || rec_ack) begin
                            rec_data   <= shift;
                            rec_valid  <= 1'b1;
                            frame_err  <= !rd;
`ifdef COMM_RECV_PARITY_EN
                            parity_err <= pbad;
`endif
                        end else
                            overrun <= 1'b1;
                    end
                endcase
        end
    end
endmodule

// File: tb/tb_communication_receive.sv
// tb_communication_receive: randomized frames checked against a frame-level model of the receiver.
module tb_communication_receive;
`ifdef COMM_RECV_PARITY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic       clk1 = 1'b0;
    logic       rst = 1'b1, rd = 1'b1, rec_en = 1'b1, rec_ack = 1'b0;
    logic [7:0] rec_data;
    logic       rec_valid, parity_err, frame_err, overrun, finish_send;

    int errors = 0, checks = 0;
    logic [7:0] md = '0;
    bit mv = 0, mp = 0, mf = 0, mo = 0;

    communication_receive #(.DATA_W(8)) dut (
        .clk1(clk1), .rst(rst), .rd(rd), .rec_en(rec_en), .rec_ack(rec_ack),
        .rec_data(rec_data), .rec_valid(rec_valid), .parity_err(parity_err),
        .frame_err(frame_err), .overrun(overrun), .finish_send(finish_send)
    );

    always #5 clk1 = ~clk1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string t);
        chk({t, "_data"}, 32'(rec_data), 32'(md));
        chk({t, "_valid"}, 32'(rec_valid), 32'(mv));
        chk({t, "_perr"}, 32'(parity_err), 32'(mp));
        chk({t, "_ferr"}, 32'(frame_err), 32'(mf));
        chk({t, "_ovr"}, 32'(overrun), 32'(mo));
    endtask

    task automatic frame(input logic [7:0] d, input bit pbad, input bit sbit, input bit ack);
        logic [10:0] bits;
        bits = {sbit, (^d) ^ pbad, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk1);
            rd = bits[i];
            rec_ack = (i == 10) && ack;
        end
        @(negedge clk1);
        rd = 1'b1;
        rec_ack = 1'b0;
        if (!mv || ack) begin
            md = d;
            mv = 1;
            mp = PEN && pbad;
            mf = !sbit;
        end else
            mo = 1;
        check_all("frame");
        chk("fs_busy", 32'(finish_send), 32'(0));
    endtask

    task automatic ack_pulse();
        @(negedge clk1);
        rec_ack = 1'b1;
        @(negedge clk1);
        rec_ack = 1'b0;
        mv = 0;
        chk("ack_valid", 32'(rec_valid), 32'(0));
        @(negedge clk1);
        chk("ack_fs", 32'(finish_send), 32'(1));
    endtask

    task automatic partial(input int n);
        for (int i = 0; i <= n; i++) begin
            @(negedge clk1);
            rd = (i == 0) ? 1'b0 : 1'($urandom_range(1));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk1);
        check_all("reset");
        chk("reset_fs", 32'(finish_send), 32'(0));
        rst = 1'b0;
        @(negedge clk1);
        @(negedge clk1);
        chk("idle_fs", 32'(finish_send), 32'(1));

        frame(8'hA5, 0, 1, 0);
        ack_pulse();
        frame(8'h01, 1, 1, 0);
        ack_pulse();
        frame(8'h3C, 0, 0, 0);
        ack_pulse();
        frame(8'h11, 0, 1, 0);
        frame(8'h22, 0, 1, 0);
        frame(8'h33, 0, 1, 1);
        ack_pulse();

        partial(4);
        @(negedge clk1);
        rec_en = 1'b0;
        rd = 1'b0;
        @(negedge clk1);
        @(negedge clk1);
        chk("abort_fs", 32'(finish_send), 32'(0));
        rec_en = 1'b1;
        rd = 1'b1;
        repeat (14) @(negedge clk1);
        check_all("abort");
        frame(8'h5A, 0, 1, 0);
        ack_pulse();

        partial(5);
        @(negedge clk1);
        rst = 1'b1;
        rd = 1'b1;
        @(negedge clk1);
        rst = 1'b0;
        md = '0; mv = 0; mp = 0; mf = 0; mo = 0;
        check_all("midrst");
        chk("midrst_fs", 32'(finish_send), 32'(0));
        @(negedge clk1);
        frame(8'hFF, 0, 1, 0);
        ack_pulse();

        for (int n = 0; n < 40; n++) begin
            frame(8'($urandom), $urandom_range(3) == 0, $urandom_range(3) != 0, 1'($urandom_range(1)));
            if ($urandom_range(1) == 1) ack_pulse();
            repeat ($urandom_range(2)) @(negedge clk1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/communication_receive.md
# communication_receive

Serial frame receiver forming the far end of the single-wire link driven by `communication_send`. It samples the line on the rising edge of the forwarded bit clock and checks the start, data, parity and stop bits. Each good or flagged byte goes into a one-entry holding register, which the host reads with a valid/ack handshake. It drives `finish_send` back to the transmitter, so a new frame is requested only when the holding register is free.

## Interface
- `DATA_W`, 8: data bits per frame, sent LSB first.
- `clk1`  in  1  bit clock (the transmitter's forwarded `freq`); all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rd`  in  1  serial line: idle 1, start 0, data, parity, stop 1.
- `rec_en`  in  1  receiver enable; low aborts any frame in progress.
- `rec_ack`  in  1  host consumed `rec_data`; honoured only while `rec_valid`=1.
- `rec_data`  out  DATA_W  last received byte, held until overwritten.
- `rec_valid`  out  1  holding register full.
- `parity_err`  out  1  parity mismatch for the byte in the holding register.
- `frame_err`  out  1  stop bit sampled 0 for the byte in the holding register.
- `overrun`  out  1  sticky: a frame completed while the holding register was full.
- `finish_send`  out  1  ready to transmitter: `rec_en` & idle & holding register empty.

## Operation
- States: IDLE, DATA, PARITY, STOP.
- IDLE: when `rec_en`=1 and `rd`=0 is sampled, this is the start bit. Clear the bit counter and go to DATA. A sample of `rd`=1 stays in IDLE.
- DATA: shift `rd` into bit `cnt` of the shift register (LSB first) and accumulate the XOR. When `cnt`=DATA_W-1, go to PARITY.
- PARITY: sample the parity bit. Even parity is used: the parity bit equals the XOR of the data bits. Go to STOP.
- STOP: sample the stop bit, complete the frame, return to IDLE.
- Frame completion when `rec_valid`=0, or `rec_ack`=1 in the same cycle:
  - load `rec_data`;
  - set `rec_valid`=1;
  - `parity_err` = (parity sample ≠ data XOR);
  - `frame_err` = (stop sample = 0).
- Frame completion when `rec_valid`=1 and `rec_ack`=0: the new frame is discarded, the old data and flags are kept, and `overrun` is set.
- `rec_ack` with `rec_valid`=1 and no completion in the same cycle: `rec_valid` goes to 0. The flags hold their values until the next load.
- `rec_ack` while `rec_valid`=0 is ignored.
- `rec_en`=0 in any state: go to IDLE next edge and discard the partial shift register. The holding register and flags are unaffected.
- `overrun` clears only on `rst`.
- `rst`=1: every output goes to 0, including `rec_data`=0x00 and `finish_send`=0, and the FSM goes to IDLE. This takes effect on the edge even mid-frame.

## Timing
- One sample per `clk1` rising edge, one bit per cycle. The line is stable at the sampling edge because the transmitter updates it after the same edge.
- Start bit sampled at edge E. Data bits at E+1..E+8, parity at E+9, stop at E+10.
- `rec_valid`, `rec_data` and both error flags are visible after edge E+10. Total latency is 11 cycles from the start sample.
- Back-to-back frames are supported: a start bit may be sampled at E+11.
- `finish_send` is registered. It drops on the edge after the start is sampled, or on the edge where `rec_valid` sets. It rises one edge after the FSM is in IDLE with `rec_valid`=0 and `rec_en`=1.
- The transmitter's extended stop/idle (3 cycles of 1 after parity) is absorbed in IDLE.

## Configuration
- `COMM_RECV_PARITY_EN` defined: the PARITY state checks even parity and drives `parity_err` as above.
- Not defined:
  - PARITY still consumes the parity slot, so frame timing is unchanged;
  - the sample is discarded and the XOR logic is removed;
  - `parity_err` is tied to 0.

## Test plan
- After `rst`, send 0xA5 (data bits 1,0,1,0,0,1,0,1, parity 0, stop 1) → after edge E+10: `rec_data`=0xA5, `rec_valid`=1, `parity_err`=0, `frame_err`=0, `finish_send`=0. Pulse `rec_ack` → `rec_valid`=0, then `finish_send`=1.
- Send 0x01 with parity bit 0 → `parity_err`=1 with `COMM_RECV_PARITY_EN`; `parity_err`=0 without it. `rec_data`=0x01 in both builds.
- Send 0x3C with stop bit 0 → `rec_data`=0x3C, `frame_err`=1.
- Send 0x11 with no ack, then send 0x22 → `rec_data` stays 0x11, `overrun`=1. Send 0x33 with `rec_ack`=1 in its completion cycle → `rec_data`=0x33, `rec_valid`=1.
- Drop `rec_en` after 4 data bits, then send a full 0x5A → `rec_data`=0x5A, no spurious byte, no flags set.
- Assert `rst` at data bit 5 → all outputs 0 on the next edge. A subsequent frame 0xFF is received correctly with `parity_err`=0.
